// File: rtl/seg_pkg.sv
// Shared 7-segment display constants and the BCD segment pattern table.
package seg_pkg;

  localparam int unsigned NUM_DIG = 6;
  localparam int unsigned BCD_W   = 4;

  // Segment vectors are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // 0-9 are standard glyphs; 10-15 are not BCD and show a dash.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern lookup.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_n_o
);

  // Table lookup; non-BCD codes resolve to the dash entry.
  always_comb begin
    seg_n_o = SEG_TABLE[bcd_i];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver with per-frame digit snapshot,
// anti-ghost blanking window and leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned N         = 10,
  parameter int unsigned NUM_DIG   = 6,
  parameter int unsigned BLANK_CNT = 16,
  parameter int unsigned LZB_DIGS  = 2
) (
  input  logic                 clk,
  input  logic                 hard_reset,
  input  logic [N-1:0]         dp_count,
  input  logic [4*NUM_DIG-1:0] digits_in,
  input  logic [NUM_DIG-1:0]   dp_mask,
  input  logic                 lzb_en,
  output logic [6:0]           seg_n,
  output logic                 dp_n,
  output logic [NUM_DIG-1:0]   dig_n,
  output logic                 frame_start
);

  if (BLANK_CNT >= (2 ** N)) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CNT must be below 2**N");
  end
  if (NUM_DIG != seg_pkg::NUM_DIG) begin : g_bad_numdig
    $error("seg_scan_driver: only six digits are supported");
  end
  if (LZB_DIGS > NUM_DIG) begin : g_bad_lzb
    $error("seg_scan_driver: LZB_DIGS exceeds digit count");
  end

  localparam logic [N-1:0] BLANK_N = BLANK_CNT[N-1:0];

  logic [2:0]                     scan_idx_q, scan_idx_d;
  logic [NUM_DIG-1:0][BCD_W-1:0]  shadow_q, shadow_d;
  logic [NUM_DIG-1:0]             shadow_dp_q, shadow_dp_d;
  logic [6:0]                     seg_q, seg_d;
  logic                           dp_q, dp_d;
  logic [NUM_DIG-1:0]             dig_q, dig_d;
  logic                           fs_q, fs_d;

  logic                           wrap;
  logic                           idx_valid;
  logic                           blank;
  logic                           snap;
  logic [2:0]                     sel;
  logic [BCD_W-1:0]               cur_nib;
  logic [6:0]                     dec_seg;
  logic [NUM_DIG-1:0]             lzb_blank;
  logic                           zero_above;

  // Segment decode of the digit currently being scanned.
  bcd_to_seg7 u_dec (
    .bcd_i   (cur_nib),
    .seg_n_o (dec_seg)
  );

  // Leading-zero mask: walk from the top digit down while the shadow stays zero.
  always_comb begin
    lzb_blank  = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < NUM_DIG; k++) begin
      zero_above = zero_above && (shadow_q[NUM_DIG-1-k] == '0);
      if (lzb_en && zero_above && ((NUM_DIG - 1 - k) >= (NUM_DIG - LZB_DIGS))
          && ((NUM_DIG - 1 - k) != 0)) begin
        lzb_blank[NUM_DIG-1-k] = 1'b1;
      end
    end
  end

  // Next-state for scan index, snapshot and registered outputs.
  always_comb begin
    wrap        = (dp_count == '1);
    idx_valid   = (scan_idx_q < 3'd6);
    sel         = idx_valid ? scan_idx_q : 3'd0;
    // An out-of-range index is treated like a blank period while it recovers.
    blank       = (dp_count < BLANK_N) || wrap || !idx_valid;
    snap        = wrap && (scan_idx_q == 3'd5);

    scan_idx_d  = scan_idx_q;
    if (!idx_valid) begin
      scan_idx_d = 3'd0;
    end else if (wrap) begin
      scan_idx_d = (scan_idx_q == 3'd5) ? 3'd0 : scan_idx_q + 3'd1;
    end

    shadow_d    = snap ? digits_in : shadow_q;
    shadow_dp_d = snap ? dp_mask : shadow_dp_q;

    cur_nib     = shadow_q[sel];
    dig_d       = blank ? '1 : ~(6'b000001 << sel);
    seg_d       = (blank || lzb_blank[sel]) ? SEG_OFF : dec_seg;
    dp_d        = blank ? 1'b1 : ~shadow_dp_q[sel];
    fs_d        = snap;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      scan_idx_q  <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      dig_q       <= '1;
      fs_q        <= 1'b0;
    end else begin
      scan_idx_q  <= scan_idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      fs_q        <= fs_d;
    end
  end

  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign dig_n       = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int N     = 10;
  localparam int BLANK = 16;
  localparam int LZB   = 2;
  localparam int PER   = 1 << N;
  localparam int FRAME = 6 * PER;

  logic        clk = 1'b0;
  logic        hard_reset;
  logic [9:0]  dp_count;
  logic [23:0] digits_in;
  logic [5:0]  dp_mask;
  logic        lzb_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  dig_n;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .N         (N),
    .NUM_DIG   (6),
    .BLANK_CNT (BLANK),
    .LZB_DIGS  (LZB)
  ) dut (
    .clk         (clk),
    .hard_reset  (hard_reset),
    .dp_count    (dp_count),
    .digits_in   (digits_in),
    .dp_mask     (dp_mask),
    .lzb_en      (lzb_en),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .dig_n       (dig_n),
    .frame_start (frame_start)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: frame-level view of the display.
  int m_idx;
  int m_dig [6];
  int m_dp  [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Glyph described by its lit segment letters.
  function automatic logic [6:0] pattern(input int v);
    string      lit;
    logic [6:0] p;
    p = 7'h7F;
    case (v)
      0: lit = "abcdef";
      1: lit = "bc";
      2: lit = "abged";
      3: lit = "abgcd";
      4: lit = "fgbc";
      5: lit = "afgcd";
      6: lit = "afgedc";
      7: lit = "abc";
      8: lit = "abcdefg";
      9: lit = "abcdfg";
      default: lit = "g";
    endcase
    for (int k = 0; k < lit.len(); k++) p[int'(lit[k]) - 97] = 1'b0;
    return p;
  endfunction

  function automatic bit model_lzb(input int i);
    if (!lzb_en || i == 0 || i < 6 - LZB) return 1'b0;
    for (int j = i; j < 6; j++) if (m_dig[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    for (int i = 0; i < 6; i++) begin
      m_dig[i] = 0;
      m_dp[i]  = 0;
    end
  endtask

  // One clock with the given scan count; outputs checked against the model.
  task automatic step(input logic [9:0] dv);
    int e_dig, e_seg, e_dp, e_fs;
    bit wr, bl;
    dp_count = dv;
    wr    = (dv == 10'h3FF);
    bl    = (int'(dv) < BLANK) || wr;
    e_dig = bl ? 'h3F : (~(1 << m_idx)) & 'h3F;
    e_seg = (bl || model_lzb(m_idx)) ? 'h7F : int'(pattern(m_dig[m_idx]));
    e_dp  = bl ? 1 : (m_dp[m_idx] != 0 ? 0 : 1);
    e_fs  = (wr && m_idx == 5) ? 1 : 0;
    if (wr) begin
      if (m_idx == 5) begin
        for (int i = 0; i < 6; i++) begin
          m_dig[i] = int'(digits_in[4*i +: 4]);
          m_dp[i]  = int'(dp_mask[i]);
        end
      end
      m_idx = (m_idx + 1) % 6;
    end
    @(posedge clk);
    #1;
    chk("dig_n", int'(dig_n), e_dig);
    chk("seg_n", int'(seg_n), e_seg);
    chk("dp_n", int'(dp_n), e_dp);
    chk("frame_start", int'(frame_start), e_fs);
  endtask

  task automatic goto_idx(input int target);
    for (int n = 0; n < 12 && m_idx != target; n++) step(10'h3FF);
  endtask

  task automatic snapshot();
    goto_idx(5);
    step(10'h3FF);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg_n"}, int'(seg_n), 'h7F);
    chk({tag, "_dp_n"}, int'(dp_n), 1);
    chk({tag, "_dig_n"}, int'(dig_n), 'h3F);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  typedef struct {
    logic [23:0] digs;
    logic [5:0]  dpm;
    logic        lzb;
    int          dig;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vt [15];
  logic [6:0] exp_123456 [6];

  initial begin
    int cnt, lit0, first_fs, d;
    logic [5:0] e_dig;

    vt[0]  = '{24'h000042, 6'b000000, 1'b1, 5, 7'h7F,      1'b1};
    vt[1]  = '{24'h000042, 6'b000000, 1'b1, 4, 7'h7F,      1'b1};
    vt[2]  = '{24'h000042, 6'b000000, 1'b1, 3, 7'b1000000, 1'b1};
    vt[3]  = '{24'h000042, 6'b000000, 1'b1, 2, 7'b1000000, 1'b1};
    vt[4]  = '{24'h000042, 6'b000000, 1'b0, 5, 7'b1000000, 1'b1};
    vt[5]  = '{24'h000042, 6'b000000, 1'b1, 1, 7'b0011001, 1'b1};
    vt[6]  = '{24'h00000C, 6'b000100, 1'b0, 0, 7'b0111111, 1'b1};
    vt[7]  = '{24'h00000C, 6'b000100, 1'b0, 2, 7'b1000000, 1'b0};
    vt[8]  = '{24'h00000C, 6'b000100, 1'b0, 1, 7'b1000000, 1'b1};
    vt[9]  = '{24'h000000, 6'b100000, 1'b1, 5, 7'h7F,      1'b0};
    vt[10] = '{24'h000000, 6'b000000, 1'b1, 0, 7'b1000000, 1'b1};
    vt[11] = '{24'h050000, 6'b000000, 1'b1, 4, 7'b0010010, 1'b1};
    vt[12] = '{24'h123456, 6'b000000, 1'b0, 5, 7'b1111001, 1'b1};
    vt[13] = '{24'h123456, 6'b000000, 1'b0, 0, 7'b0000010, 1'b1};
    vt[14] = '{24'h00F000, 6'b000000, 1'b1, 3, 7'b0111111, 1'b1};

    exp_123456[0] = 7'b0000010;
    exp_123456[1] = 7'b0010010;
    exp_123456[2] = 7'b0011001;
    exp_123456[3] = 7'b0110000;
    exp_123456[4] = 7'b0100100;
    exp_123456[5] = 7'b1111001;

    // Power-up reset with the real counter held at zero.
    hard_reset = 1'b0;
    dp_count   = '0;
    digits_in  = 24'h123456;
    dp_mask    = '0;
    lzb_en     = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    hard_reset = 1'b1;

    // Free-running counter: blank window, first frame, then the 123456 frame.
    cnt      = 0;
    lit0     = 0;
    first_fs = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step(cnt[9:0]);
      if (k == 16) chk("first_lit_minus1", int'(dig_n), 'h3F);
      if (k == 17) chk("first_lit", int'(dig_n), 'h3E);
      if (k <= PER && dig_n == 6'h3E) lit0++;
      if (frame_start && first_fs < 0) first_fs = k;
      if (k > FRAME && ((k - 1) % PER) == 500) begin
        d     = (k - 1) / PER - 6;
        e_dig = ~(6'b000001 << d);
        chk("frame2_seg", int'(seg_n), int'(exp_123456[d]));
        chk("frame2_dig", int'(dig_n), int'(e_dig));
      end
      cnt = (cnt + 1) % PER;
    end
    chk("digit0_lit_cycles", lit0, PER - BLANK - 1);
    chk("first_frame_start", first_fs, FRAME);

    // Randomized traffic with frequent wraps and mid-frame input changes.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits_in = 24'($urandom);
        dp_mask   = 6'($urandom);
        lzb_en    = 1'($urandom);
      end
      case ($urandom_range(0, 3))
        0:       step(10'h3FF);
        1:       step(10'($urandom_range(0, 20)));
        default: step(10'($urandom_range(0, 1022)));
      endcase
    end

    // Table-driven display vectors.
    for (int v = 0; v < 15; v++) begin
      digits_in = vt[v].digs;
      dp_mask   = vt[v].dpm;
      lzb_en    = vt[v].lzb;
      snapshot();
      goto_idx(vt[v].dig);
      step(10'd500);
      e_dig = ~(6'b000001 << vt[v].dig);
      chk($sformatf("vec%0d_seg", v), int'(seg_n), int'(vt[v].seg));
      chk($sformatf("vec%0d_dp", v), int'(dp_n), int'(vt[v].dp));
      chk($sformatf("vec%0d_dig", v), int'(dig_n), int'(e_dig));
    end

    // Digits changed mid-frame stay hidden until the next snapshot.
    digits_in = 24'h000000;
    dp_mask   = '0;
    lzb_en    = 1'b0;
    snapshot();
    goto_idx(2);
    step(10'd500);
    digits_in = 24'h999999;
    for (int i = 3; i < 6; i++) begin
      goto_idx(i);
      step(10'd500);
      chk($sformatf("midframe_old_d%0d", i), int'(seg_n), 'h40);
    end
    step(10'h3FF);
    chk("midframe_snapshot", int'(frame_start), 1);
    for (int i = 0; i < 6; i++) begin
      goto_idx(i);
      step(10'd500);
      chk($sformatf("midframe_new_d%0d", i), int'(seg_n), 'h10);
    end

    // Asynchronous reset mid-frame, then a full frame from the restarted counter.
    digits_in = 24'h123456;
    goto_idx(4);
    step(10'd500);
    chk("pre_reset_dig", int'(dig_n), 'h2F);
    #2;
    hard_reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("held_reset");
    hard_reset = 1'b1;
    cnt      = 0;
    first_fs = -1;
    for (int k = 1; k <= FRAME + 50 && first_fs < 0; k++) begin
      step(cnt[9:0]);
      if (frame_start) first_fs = k;
      cnt = (cnt + 1) % PER;
    end
    chk("post_reset_frame_start", first_fs, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
